// File: rtl/sram_req_arbiter.sv
// ---------------------------------------------------------------------------
// sram_req_arbiter
//
// Shares one SRAM-like memory port between the fetch stage (inst master) and
// the mem stage (data master). A granted request is driven to memory in the
// grant cycle. If memory does not accept it in that cycle, it is copied into a
// hold register and replayed unchanged until memory accepts it. Accepted
// transactions are tracked in order in a small FIFO, up to OUTST deep. Each
// response is steered back to its owner. Fetch responses that were cancelled
// by a branch or flush are dropped.
//
// Configuration macro:
//   ARB_RR_EN  defined   : round-robin between the masters. When both masters
//                          request, the one that did not win last time wins.
//              undefined : fixed priority. The data master wins over inst.
//
// Parameters:
//   OUTST  maximum number of accepted but unanswered transactions (1..4).
//
// Ports:
//   clk, rst                  clock; synchronous active-high reset
//   inst_req/addr             fetch read request
//   inst_cancel               discard every inst transaction captured so far
//   inst_addr_ok              fetch request captured this cycle
//   inst_data_ok/rdata        fetch response (rdata is 0 when data_ok is 0)
//   data_req/wr/wstrb/addr/wdata   data request
//   data_addr_ok              data request captured this cycle
//   data_data_ok/rdata        data response or write ack (rdata is 0 when idle)
//   mem_req/wr/wstrb/addr/wdata    request to memory
//   mem_addr_ok               memory accepts the request
//   mem_data_ok/rdata         memory response, in acceptance order
// ---------------------------------------------------------------------------
module sram_req_arbiter #(
    parameter int OUTST = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    input  logic        inst_cancel,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    localparam logic       OWN_INST = 1'b0;
    localparam logic       OWN_DATA = 1'b1;
    // The order FIFO always has four physical slots, so a 2-bit pointer
    // indexes it exactly. Only the first OUTST slots are used.
    localparam int         DEPTH    = 4;
    localparam logic [2:0] CNT_MAX  = 3'(OUTST);
    localparam logic [1:0] PTR_LAST = 2'(OUTST - 1);

    typedef enum logic {
        ARB_GRANT = 1'b0,
        ARB_HOLD  = 1'b1
    } arb_state_t;

    // The pointer wraps after slot OUTST-1. A plain overflow would not wrap
    // correctly when OUTST is 3.
    function automatic logic [1:0] ptr_inc(input logic [1:0] ptr);
        ptr_inc = (ptr == PTR_LAST) ? 2'd0 : ptr + 2'd1;
    endfunction

    arb_state_t  state_r, state_nxt_s;

    logic        hold_owner_r, hold_wr_r, hold_disc_r;
    logic [3:0]  hold_wstrb_r;
    logic [31:0] hold_addr_r, hold_wdata_r;

    logic        fifo_owner_r [DEPTH];
    logic        fifo_disc_r  [DEPTH];
    logic [1:0]  rd_ptr_r, wr_ptr_r;
    logic [2:0]  cnt_r;

    logic        slot_free_s, win_data_s, grant_s, hold_load_s;
    logic        req_s, wr_s;
    logic [3:0]  wstrb_s;
    logic [31:0] addr_s, wdata_s;
    logic        inst_aok_s, data_aok_s;
    logic        push_s, push_owner_s, push_disc_s;
    logic        pop_s, head_owner_s, head_disc_s;
    logic        inst_dok_s, data_dok_s;
    logic [31:0] inst_rdata_s, data_rdata_s;

    assign slot_free_s = (cnt_r < CNT_MAX);

`ifdef ARB_RR_EN
    logic rr_last_r;

    // Winner selection: on a tie, the master that did not win last time wins.
    always_comb begin
        win_data_s = 1'b0;
        if (data_req && inst_req) begin
            win_data_s = (rr_last_r == OWN_INST);
        end else begin
            win_data_s = data_req;
        end
    end

    // Remember which master won the most recent capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_last_r <= OWN_INST;
        end else if (grant_s) begin
            rr_last_r <= win_data_s;
        end
    end
`else
    // Winner selection: the data master always wins.
    always_comb begin
        win_data_s = 1'b0;
        if (data_req) begin
            win_data_s = 1'b1;
        end else begin
            win_data_s = 1'b0;
        end
    end
`endif

    // Grant/hold control: drive the memory request and pick the next state.
    always_comb begin
        state_nxt_s = state_r;
        req_s       = 1'b0;
        wr_s        = 1'b0;
        wstrb_s     = 4'h0;
        addr_s      = 32'h0;
        wdata_s     = 32'h0;
        inst_aok_s  = 1'b0;
        data_aok_s  = 1'b0;
        grant_s     = 1'b0;
        hold_load_s = 1'b0;
        if (rst) begin
            state_nxt_s = ARB_GRANT;
        end else begin
            case (state_r)
                ARB_HOLD: begin
                    req_s   = 1'b1;
                    wr_s    = hold_wr_r;
                    wstrb_s = hold_wstrb_r;
                    addr_s  = hold_addr_r;
                    wdata_s = hold_wdata_r;
                    if (mem_addr_ok) begin
                        state_nxt_s = ARB_GRANT;
                    end else begin
                        state_nxt_s = ARB_HOLD;
                    end
                end
                ARB_GRANT: begin
                    if (slot_free_s && (inst_req || data_req)) begin
                        grant_s = 1'b1;
                        req_s   = 1'b1;
                        if (win_data_s) begin
                            wr_s       = data_wr;
                            wstrb_s    = data_wstrb;
                            addr_s     = data_addr;
                            wdata_s    = data_wdata;
                            data_aok_s = 1'b1;
                        end else begin
                            addr_s     = inst_addr;
                            inst_aok_s = 1'b1;
                        end
                        if (mem_addr_ok) begin
                            state_nxt_s = ARB_GRANT;
                        end else begin
                            state_nxt_s = ARB_HOLD;
                            hold_load_s = 1'b1;
                        end
                    end else begin
                        state_nxt_s = ARB_GRANT;
                    end
                end
                default: begin
                    state_nxt_s = ARB_GRANT;
                end
            endcase
        end
    end

    // Arbiter state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ARB_GRANT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Hold register: capture a request that memory did not take, and mark a
    // held fetch as discarded when a cancel arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_owner_r <= OWN_INST;
            hold_wr_r    <= 1'b0;
            hold_wstrb_r <= 4'h0;
            hold_addr_r  <= 32'h0;
            hold_wdata_r <= 32'h0;
            hold_disc_r  <= 1'b0;
        end else if (hold_load_s) begin
            hold_owner_r <= win_data_s;
            hold_wr_r    <= wr_s;
            hold_wstrb_r <= wstrb_s;
            hold_addr_r  <= addr_s;
            hold_wdata_r <= wdata_s;
            hold_disc_r  <= inst_cancel & ~win_data_s;
        end else if (inst_cancel && (hold_owner_r == OWN_INST)) begin
            hold_disc_r  <= 1'b1;
        end
    end

    // Push/pop decode. A cancel in the same cycle also covers the entry being
    // pushed and the entry being popped.
    always_comb begin
        push_s       = req_s & mem_addr_ok;
        push_owner_s = OWN_INST;
        push_disc_s  = 1'b0;
        if (state_r == ARB_HOLD) begin
            push_owner_s = hold_owner_r;
            push_disc_s  = hold_disc_r | (inst_cancel & (hold_owner_r == OWN_INST));
        end else begin
            push_owner_s = win_data_s;
            push_disc_s  = inst_cancel & ~win_data_s;
        end
        pop_s        = mem_data_ok & (cnt_r != 3'd0) & ~rst;
        head_owner_s = fifo_owner_r[rd_ptr_r];
        head_disc_s  = fifo_disc_r[rd_ptr_r] | (inst_cancel & (head_owner_s == OWN_INST));
    end

    // Response routing: the response reaches its owner in the same cycle.
    // The other master sees data_ok=0 and rdata=0.
    always_comb begin
        inst_dok_s   = 1'b0;
        data_dok_s   = 1'b0;
        inst_rdata_s = 32'h0;
        data_rdata_s = 32'h0;
        if (pop_s && (head_owner_s == OWN_DATA)) begin
            data_dok_s   = 1'b1;
            data_rdata_s = mem_rdata;
        end else if (pop_s && !head_disc_s) begin
            inst_dok_s   = 1'b1;
            inst_rdata_s = mem_rdata;
        end else begin
            inst_dok_s   = 1'b0;
        end
    end

    // Order FIFO: tracks owner and discard flag for each accepted transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_owner_r[i] <= OWN_INST;
                fifo_disc_r[i]  <= 1'b0;
            end
            rd_ptr_r <= 2'd0;
            wr_ptr_r <= 2'd0;
            cnt_r    <= 3'd0;
        end else begin
            if (inst_cancel) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (fifo_owner_r[i] == OWN_INST) begin
                        fifo_disc_r[i] <= 1'b1;
                    end
                end
            end
            if (push_s) begin
                fifo_owner_r[wr_ptr_r] <= push_owner_s;
                fifo_disc_r[wr_ptr_r]  <= push_disc_s;
                wr_ptr_r               <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({push_s, pop_s})
                2'b10:   cnt_r <= cnt_r + 3'd1;
                2'b01:   cnt_r <= cnt_r - 3'd1;
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    assign mem_req      = req_s;
    assign mem_wr       = wr_s;
    assign mem_wstrb    = wstrb_s;
    assign mem_addr     = addr_s;
    assign mem_wdata    = wdata_s;
    assign inst_addr_ok = inst_aok_s;
    assign data_addr_ok = data_aok_s;
    assign inst_data_ok = inst_dok_s;
    assign inst_rdata   = inst_rdata_s;
    assign data_data_ok = data_dok_s;
    assign data_rdata   = data_rdata_s;

    sram_req_arbiter_chk u_chk (
        .clk         (clk),
        .rst         (rst),
        .mem_data_ok (mem_data_ok),
        .mem_req     (mem_req),
        .mem_addr_ok (mem_addr_ok),
        .cnt         (cnt_r),
        .mem_addr    (mem_addr)
    );

endmodule

// ---------------------------------------------------------------------------
// sram_req_arbiter_chk
//
// Simulation checks for the memory-side protocol.
// Ports: clk, rst, mem_data_ok, mem_req, mem_addr_ok, cnt (outstanding count),
// mem_addr.
// ---------------------------------------------------------------------------
module sram_req_arbiter_chk (
    input logic        clk,
    input logic        rst,
    input logic        mem_data_ok,
    input logic        mem_req,
    input logic        mem_addr_ok,
    input logic [2:0]  cnt,
    input logic [31:0] mem_addr
);

    // A response with nothing outstanding breaks the in-order contract.
    a_no_pop_empty: assert property (@(posedge clk) disable iff (rst)
        mem_data_ok |-> (cnt != 3'd0));

    // A request that was not accepted stays asserted with the same address.
    a_req_stable: assert property (@(posedge clk) disable iff (rst)
        (mem_req && !mem_addr_ok) |=> (mem_req && $stable(mem_addr)));

endmodule

// File: tb/tb_sram_req_arbiter.sv
module tb_sram_req_arbiter;

    localparam int OUTST = 2;

    logic        clk;
    logic        rst;
    logic        inst_req, inst_cancel, inst_addr_ok, inst_data_ok;
    logic [31:0] inst_addr, inst_rdata;
    logic        data_req, data_wr, data_addr_ok, data_data_ok;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int checks   = 0;
    int failures = 0;

    // Reference model: a queue of outstanding {owner(1=data), discarded},
    // plus one pending unaccepted request.
    bit          m_hold_v, m_hold_owner, m_hold_wr, m_hold_disc, m_rr_last;
    bit [3:0]    m_hold_wstrb;
    bit [31:0]   m_hold_addr, m_hold_wdata;
    bit [1:0]    m_q[$];

    sram_req_arbiter #(.OUTST(OUTST)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_cancel(inst_cancel),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        inst_req = 1'b0; inst_addr = 32'h0; inst_cancel = 1'b0;
        data_req = 1'b0; data_wr = 1'b0; data_wstrb = 4'h0;
        data_addr = 32'h0; data_wdata = 32'h0;
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'h0;
    endtask

    task automatic data_rd(input logic [31:0] a);
        data_req = 1'b1; data_wr = 1'b0; data_wstrb = 4'h0; data_addr = a;
    endtask

    // Checks every output against the model, then advances the model by one cycle.
    task automatic model_cycle();
        bit e_req, e_wr, e_iaok, e_daok, e_idok, e_ddok, grant, wd, pop, h_own, h_disc;
        bit [3:0]  e_wstrb;
        bit [31:0] e_addr, e_wdata, e_irdata, e_drdata;
        e_req = 0; e_wr = 0; e_iaok = 0; e_daok = 0; e_idok = 0; e_ddok = 0;
        e_wstrb = 4'h0; e_addr = 32'h0; e_wdata = 32'h0; e_irdata = 32'h0; e_drdata = 32'h0;
        if (rst) begin
            chk("rst_mem_req", mem_req, 32'h0);
            chk("rst_mem_addr", mem_addr, 32'h0);
            chk("rst_mem_wdata", mem_wdata, 32'h0);
            chk("rst_iaok", inst_addr_ok, 32'h0);
            chk("rst_daok", data_addr_ok, 32'h0);
            chk("rst_idok", inst_data_ok, 32'h0);
            chk("rst_ddok", data_data_ok, 32'h0);
            m_hold_v = 0; m_rr_last = 0; m_q.delete();
            return;
        end
        grant = !m_hold_v && (m_q.size() < OUTST) && (inst_req || data_req);
`ifdef ARB_RR_EN
        wd = data_req && (!inst_req || !m_rr_last);
`else
        wd = data_req;
`endif
        if (m_hold_v) begin
            e_req = 1; e_wr = m_hold_wr; e_wstrb = m_hold_wstrb;
            e_addr = m_hold_addr; e_wdata = m_hold_wdata;
        end else if (grant) begin
            e_req = 1;
            if (wd) begin
                e_wr = data_wr; e_wstrb = data_wstrb; e_addr = data_addr; e_wdata = data_wdata;
                e_daok = 1;
            end else begin
                e_addr = inst_addr; e_iaok = 1;
            end
        end
        pop = mem_data_ok && (m_q.size() > 0);
        if (pop) begin
            h_own  = m_q[0][1];
            h_disc = m_q[0][0] || (inst_cancel && !h_own);
            if (h_own) begin
                e_ddok = 1; e_drdata = mem_rdata;
            end else if (!h_disc) begin
                e_idok = 1; e_irdata = mem_rdata;
            end
        end
        chk("mem_req", mem_req, 32'(e_req));
        if (e_req) begin
            chk("mem_addr", mem_addr, e_addr);
            chk("mem_wr", mem_wr, 32'(e_wr));
            if (e_wr) begin
                chk("mem_wstrb", mem_wstrb, 32'(e_wstrb));
                chk("mem_wdata", mem_wdata, e_wdata);
            end
        end
        chk("inst_addr_ok", inst_addr_ok, 32'(e_iaok));
        chk("data_addr_ok", data_addr_ok, 32'(e_daok));
        chk("inst_data_ok", inst_data_ok, 32'(e_idok));
        chk("inst_rdata", inst_rdata, e_irdata);
        chk("data_data_ok", data_data_ok, 32'(e_ddok));
        chk("data_rdata", data_rdata, e_drdata);
        if (pop) void'(m_q.pop_front());
        if (inst_cancel) begin
            foreach (m_q[i]) if (!m_q[i][1]) m_q[i] = 2'b01;
            if (m_hold_v && !m_hold_owner) m_hold_disc = 1;
        end
        if (m_hold_v) begin
            if (mem_addr_ok) begin
                m_q.push_back({m_hold_owner, m_hold_disc});
                m_hold_v = 0;
            end
        end else if (grant) begin
            m_rr_last = wd;
            if (mem_addr_ok) begin
                m_q.push_back({wd, inst_cancel && !wd});
            end else begin
                m_hold_v = 1; m_hold_owner = wd; m_hold_wr = e_wr; m_hold_wstrb = e_wstrb;
                m_hold_addr = e_addr; m_hold_wdata = e_wdata; m_hold_disc = inst_cancel && !wd;
            end
        end
    endtask

    task automatic finish_cycle();
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        @(negedge clk);
        finish_cycle();
    endtask

    task automatic drain();
        idle();
        for (int k = 0; k < 10 && (m_q.size() > 0 || m_hold_v); k++) begin
            mem_addr_ok = 1'b1;
            mem_data_ok = (m_q.size() > 0);
            mem_rdata   = $urandom;
            tick();
        end
        idle();
        tick();
    endtask

    initial begin
        idle();
        // Reset with requests present: every output must stay at 0.
        rst = 1'b1; inst_req = 1'b1; inst_addr = 32'h1c000000; data_rd(32'h1c001000);
        tick(); tick();
        rst = 1'b0; idle();
        tick();

        // 1: single fetch, response two cycles later.
        inst_req = 1'b1; inst_addr = 32'h1c000000; mem_addr_ok = 1'b1;
        @(negedge clk); chk("t1_iaok", inst_addr_ok, 32'h1); finish_cycle();
        idle(); tick();
        mem_data_ok = 1'b1; mem_rdata = 32'h02800000;
        @(negedge clk);
        chk("t1_idok", inst_data_ok, 32'h1);
        chk("t1_irdata", inst_rdata, 32'h02800000);
        chk("t1_ddok", data_data_ok, 32'h0);
        finish_cycle();
        idle(); tick();

        // 2: both masters in the same cycle; data wins, responses return in order.
        inst_req = 1'b1; inst_addr = 32'h1c000004; data_rd(32'h1c001000); mem_addr_ok = 1'b1;
        @(negedge clk); chk("t2_daok", data_addr_ok, 32'h1); chk("t2_iaok0", inst_addr_ok, 32'h0); finish_cycle();
        data_req = 1'b0;
        @(negedge clk); chk("t2_iaok1", inst_addr_ok, 32'h1); finish_cycle();
        idle(); mem_data_ok = 1'b1; mem_rdata = 32'h11111111;
        @(negedge clk); chk("t2_ddok", data_data_ok, 32'h1); chk("t2_idok0", inst_data_ok, 32'h0); finish_cycle();
        mem_data_ok = 1'b1; mem_rdata = 32'h22222222;
        @(negedge clk); chk("t2_idok", inst_data_ok, 32'h1); chk("t2_irdata", inst_rdata, 32'h22222222); finish_cycle();
        idle(); tick();

        // 3: write stalled by memory for three cycles; request stays constant.
        data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'hf; data_addr = 32'h1c002000; data_wdata = 32'hdeadbeef;
        @(negedge clk); chk("t3_daok", data_addr_ok, 32'h1); finish_cycle();
        for (int c = 1; c <= 3; c++) begin
            idle(); inst_req = 1'b1; inst_addr = 32'h1c000040; mem_addr_ok = (c == 3);
            @(negedge clk);
            chk("t3_mreq", mem_req, 32'h1);
            chk("t3_maddr", mem_addr, 32'h1c002000);
            chk("t3_mwdata", mem_wdata, 32'hdeadbeef);
            chk("t3_iaok", inst_addr_ok, 32'h0);
            finish_cycle();
        end
        idle(); mem_data_ok = 1'b1;
        @(negedge clk); chk("t3_ack", data_data_ok, 32'h1); finish_cycle();
        idle(); tick();

        // 4: outstanding limit reached, third request waits for a response.
        mem_addr_ok = 1'b1;
        data_rd(32'h1c003000); tick();
        data_rd(32'h1c003004); tick();
        data_rd(32'h1c003008);
        @(negedge clk); chk("t4_daok_full", data_addr_ok, 32'h0); chk("t4_mreq_full", mem_req, 32'h0); finish_cycle();
        mem_data_ok = 1'b1; mem_rdata = 32'h33333333;
        @(negedge clk); chk("t4_ddok", data_data_ok, 32'h1); chk("t4_daok_pop", data_addr_ok, 32'h0); finish_cycle();
        mem_data_ok = 1'b0;
        @(negedge clk); chk("t4_daok_next", data_addr_ok, 32'h1); finish_cycle();
        drain();

        // 5: two fetches outstanding, cancelled; later fetch still delivered.
        mem_addr_ok = 1'b1; inst_req = 1'b1;
        inst_addr = 32'h1c000010; tick();
        inst_addr = 32'h1c000014; tick();
        idle(); inst_cancel = 1'b1; tick();
        idle(); mem_data_ok = 1'b1; mem_rdata = 32'h44444444;
        @(negedge clk); chk("t5_drop0", inst_data_ok, 32'h0); finish_cycle();
        @(negedge clk); chk("t5_drop1", inst_data_ok, 32'h0); finish_cycle();
        idle(); mem_addr_ok = 1'b1; inst_req = 1'b1; inst_addr = 32'h1c000008; tick();
        idle(); mem_data_ok = 1'b1; mem_rdata = 32'h55555555;
        @(negedge clk); chk("t5_idok", inst_data_ok, 32'h1); chk("t5_irdata", inst_rdata, 32'h55555555); finish_cycle();
        idle(); tick();

        // 7: cancel with a same-cycle capture and a same-cycle inst pop.
        mem_addr_ok = 1'b1; inst_req = 1'b1; inst_addr = 32'h1c000020; tick();
        inst_addr = 32'h1c000024; inst_cancel = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'h66666666;
        @(negedge clk); chk("t7_iaok", inst_addr_ok, 32'h1); chk("t7_popdrop", inst_data_ok, 32'h0); finish_cycle();
        idle(); mem_data_ok = 1'b1;
        @(negedge clk); chk("t7_capdrop", inst_data_ok, 32'h0); finish_cycle();
        idle(); tick();

        // 8: cancel while a fetch waits in the hold register.
        inst_req = 1'b1; inst_addr = 32'h1c000030; tick();
        idle(); inst_cancel = 1'b1; tick();
        idle(); mem_addr_ok = 1'b1; tick();
        idle(); mem_data_ok = 1'b1;
        @(negedge clk); chk("t8_holddrop", inst_data_ok, 32'h0); finish_cycle();
        idle(); tick();

`ifdef ARB_RR_EN
        // 6: both masters always requesting: captures alternate d,i,d,i.
        for (int k = 0; k < 8; k++) begin
            inst_req = 1'b1; inst_addr = 32'h1c000100 + 32'(k * 4);
            data_rd(32'h1c004000 + 32'(k * 4));
            mem_addr_ok = 1'b1; mem_data_ok = (m_q.size() > 0); mem_rdata = $urandom;
            @(negedge clk);
            chk("t6_daok", data_addr_ok, 32'((k % 2) == 0));
            chk("t6_iaok", inst_addr_ok, 32'((k % 2) == 1));
            finish_cycle();
        end
        drain();
`endif

        // Random traffic against the model, with one reset in the middle.
        for (int i = 0; i < 400; i++) begin
            rst         = (i == 200 || i == 201);
            inst_req    = ($urandom_range(0, 2) != 0);
            inst_addr   = 32'h1c000000 | ($urandom & 32'h0000fffc);
            inst_cancel = ($urandom_range(0, 9) == 0);
            data_req    = ($urandom_range(0, 2) != 0);
            data_wr     = $urandom_range(0, 1);
            data_wstrb  = 4'($urandom);
            data_addr   = 32'h1c010000 | ($urandom & 32'h0000fffc);
            data_wdata  = $urandom;
            mem_addr_ok = ($urandom_range(0, 2) != 0);
            mem_data_ok = (m_q.size() > 0) && ($urandom_range(0, 1) == 1);
            mem_rdata   = $urandom;
            tick();
        end
        rst = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
